// File: rtl/rr_grant_encoder.sv
// Four-way round-robin arbiter with registered binary grant index; request-to-grant and release-to-drop are 1 cycle.
// Grant is held until release or abandon; no backpressure beyond that, and every grant is followed by an idle cycle.
module rr_grant_encoder #(
    parameter int IDX_W = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [2**IDX_W-1:0] req,
    input  logic               release_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [2**IDX_W-1:0] grant_onehot,
    output logic               contended,
    output logic               err_release
);

    localparam int N = 2**IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              vld_nxt;
    logic              cont_nxt;
    logic              err_nxt;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              found;

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
        vld_nxt   = grant_valid;
        cont_nxt  = contended;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                err_nxt = release_grant;
                if (found) begin
                    state_nxt = GRANT;
                    vld_nxt   = 1'b1;
                    idx_nxt   = pick;
                    ptr_nxt   = pick + IDX_W'(1);
                    cont_nxt  = ($countones(req) > 1);
                end else begin
                    cont_nxt  = 1'b0;
                end
            end
            GRANT: begin
                // Release and abandon collapse into the same single exit.
                if (release_grant || !req[grant_idx]) begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            contended   <= 1'b0;
            err_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant_valid <= vld_nxt;
            grant_idx   <= idx_nxt;
            contended   <= cont_nxt;
            err_release <= err_nxt;
        end
    end

    assign grant_onehot = grant_valid ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Randomized and directed bench for rr_grant_encoder against a behavioural round-robin model.
module tb_rr_grant_encoder;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] req;
    logic       release_grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;
    logic       contended;
    logic       err_release;

    int checks = 0;
    int failures = 0;

    rr_grant_encoder #(.IDX_W(2)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .req           (req),
        .release_grant (release_grant),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .grant_onehot  (grant_onehot),
        .contended     (contended),
        .err_release   (err_release)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: who holds the resource, and whose turn is next.
    bit m_busy;
    int m_owner;
    int m_next;
    bit m_cont;
    bit m_err;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_busy = 0; m_owner = 0; m_next = 0; m_cont = 0; m_err = 0;
        end else begin
            m_err = !m_busy && release_grant;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (req[(m_next + k) % 4]) begin
                            m_owner = (m_next + k) % 4;
                            break;
                        end
                    end
                    m_next = (m_owner + 1) % 4;
                    m_busy = 1;
                    m_cont = $countones(req) > 1;
                end else begin
                    m_cont = 0;
                end
            end else if (release_grant || !req[m_owner]) begin
                m_busy = 0;
                m_owner = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        check("model_grant_valid", 32'(grant_valid), 32'(m_busy));
        check("model_grant_idx", 32'(grant_idx), m_busy ? 32'(m_owner) : 32'd0);
        check("model_grant_onehot", 32'(grant_onehot), m_busy ? (32'd1 << m_owner) : 32'd0);
        check("model_contended", 32'(contended), 32'(m_cont));
        check("model_err_release", 32'(err_release), 32'(m_err));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        Reset = 1'b1;
        req = 4'b0000;
        release_grant = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_onehot", 32'(grant_onehot), 32'd0);
        check("reset_cont", 32'(contended), 32'd0);
        check("reset_err", 32'(err_release), 32'd0);
        Reset = 1'b0;

        // Single request
        req = 4'b0100; tick();
        check("single_valid", 32'(grant_valid), 32'd1);
        check("single_idx", 32'(grant_idx), 32'd2);
        check("single_onehot", 32'(grant_onehot), 32'h4);
        check("single_cont", 32'(contended), 32'd0);
        release_grant = 1'b1; tick();
        check("single_release", 32'(grant_valid), 32'd0);
        release_grant = 1'b0; req = 4'b0000; tick();

        // Full contention rotation from a fresh pointer
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            release_grant = 1'b0; tick();
            check("rr_valid", 32'(grant_valid), 32'd1);
            check("rr_idx", 32'(grant_idx), 32'(order[g]));
            check("rr_cont", 32'(contended), 32'd1);
            release_grant = 1'b1; tick();
            check("rr_drop", 32'(grant_valid), 32'd0);
        end

        // Pointer wrap and priority skip (pointer is 1 here)
        release_grant = 1'b0; req = 4'b1000; tick();
        check("wrap_idx3", 32'(grant_idx), 32'd3);
        release_grant = 1'b1; tick();
        release_grant = 1'b0; req = 4'b1010; tick();
        check("wrap_skip_idx1", 32'(grant_idx), 32'd1);
        release_grant = 1'b1; tick();
        release_grant = 1'b0; req = 4'b1010; tick();
        check("skip_idx3", 32'(grant_idx), 32'd3);
        release_grant = 1'b1; tick();

        // Abandon
        release_grant = 1'b0; req = 4'b0010; tick();
        check("abandon_idx1", 32'(grant_idx), 32'd1);
        req = 4'b0000; tick();
        check("abandon_drop", 32'(grant_valid), 32'd0);
        check("abandon_err", 32'(err_release), 32'd0);
        req = 4'b0011; tick();
        check("abandon_next_idx0", 32'(grant_idx), 32'd0);
        check("abandon_next_cont", 32'(contended), 32'd1);
        release_grant = 1'b1; req = 4'b0000; tick();
        check("dual_exit_drop", 32'(grant_valid), 32'd0);
        check("dual_exit_err", 32'(err_release), 32'd0);

        // Release in IDLE: the release held across the exit edge is seen on the first idle cycle
        tick();
        check("idle_rel_err", 32'(err_release), 32'd1);
        check("idle_rel_valid", 32'(grant_valid), 32'd0);
        release_grant = 1'b0; tick();
        check("idle_rel_err_clear", 32'(err_release), 32'd0);
        check("idle_rel_valid2", 32'(grant_valid), 32'd0);

        // Asynchronous reset while granting index 2 (pointer is 1)
        req = 4'b1100; tick();
        check("pre_reset_idx2", 32'(grant_idx), 32'd2);
        check("pre_reset_cont", 32'(contended), 32'd1);
        #1 Reset = 1'b1;
        #1;
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_idx", 32'(grant_idx), 32'd0);
        check("async_onehot", 32'(grant_onehot), 32'd0);
        check("async_cont", 32'(contended), 32'd0);
        tick();
        Reset = 1'b0; req = 4'b1111; tick();
        check("post_reset_idx0", 32'(grant_idx), 32'd0);
        check("post_reset_valid", 32'(grant_valid), 32'd1);

        // Random traffic, with an occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            release_grant = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 Reset = 1'b1;
                #1 Reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
